// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: RV32I multi-cycle sequencer (FETCH/DECODE/EXEC/MEM/WB) with memory timeout and halt.
// Define MULTICYCLE_PERF_CNT_EN to build the cycle/instret performance counters; otherwise they read 0.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        imem_ack,
  input  logic        dmem_ack,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        is_halt,
  input  logic        reg_we,
  input  logic        is_branch,
  input  logic        is_jal,
  input  logic        is_jalr,
  input  logic        br_taken,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        rf_we,
  output logic [2:0]  state,
  output logic        halted,
  output logic        err,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
);
  typedef enum logic [2:0] {FETCH = 3'd0, DECODE = 3'd1, EXEC = 3'd2, MEM = 3'd3,
                            WB = 3'd4, HALT = 3'd5, ERROR = 3'd6} state_t;
  localparam logic [7:0] LAST = 8'(MEM_TIMEOUT - 1);
  state_t     st;
  logic [7:0] wait_cnt;
  logic       f_load, f_store, f_halt, f_rwe, f_br, f_jal, f_jalr, f_taken;
  logic       waiting, in_wb, retire;
  assign waiting = (st == FETCH && !imem_ack) || (st == MEM && !dmem_ack);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st <= FETCH;
      wait_cnt <= '0;
      {f_load, f_store, f_halt, f_rwe, f_br, f_jal, f_jalr, f_taken} <= '0;
    end else begin
      case (st)
        FETCH: st <= imem_ack ? DECODE : (wait_cnt == LAST) ? ERROR : FETCH;
        DECODE: begin
          {f_load, f_store, f_halt, f_rwe, f_br, f_jal, f_jalr} <=
            {is_load, is_store, is_halt, reg_we, is_branch, is_jal, is_jalr};
          st <= EXEC;
        end
        EXEC: begin
          f_taken <= br_taken;
          st <= f_halt ? HALT : (f_load || f_store) ? MEM : WB;
        end
        MEM: st <= dmem_ack ? (f_store ? FETCH : WB) : (wait_cnt == LAST) ? ERROR : MEM;
        WB: st <= FETCH;
        default: st <= st;
      endcase
      // Counter restarts whenever the request is not stalling, which covers entry to FETCH and MEM
      wait_cnt <= waiting ? wait_cnt + 8'd1 : 8'd0;
    end
  end
  // While reset is held every output reads 0, including the fetch request
  always_comb begin
    in_wb    = rst_n && st == WB;
    imem_req = rst_n && st == FETCH;
    dmem_req = rst_n && st == MEM;
    ir_we    = imem_req && imem_ack;
    dmem_we  = dmem_req && f_store;
    retire   = in_wb || (dmem_we && dmem_ack);
    pc_we    = retire;
    pc_sel   = !in_wb ? 2'd0 : f_jalr ? 2'd2 : (f_jal || (f_br && f_taken)) ? 2'd1 : 2'd0;
    rf_we    = in_wb && f_rwe;
    halted   = rst_n && st == HALT;
    err      = rst_n && st == ERROR;
    state    = rst_n ? st : FETCH;
  end
`ifdef MULTICYCLE_PERF_CNT_EN
  logic [31:0] cyc, ret;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cyc <= '0;
      ret <= '0;
    end else begin
      if (st != HALT && st != ERROR) cyc <= cyc + 32'd1;
      if (retire) ret <= ret + 32'd1;
    end
  end
  assign cycle_cnt   = cyc;
  assign instret_cnt = ret;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif
endmodule
